fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one fifo write port among NUM_REQ compression-stage producers.
- Packs {last, source id, data} into each fifo entry and exposes the read side as a valid/ready stream.
- Keeps a mirrored occupancy level with an almost-full flag for upstream throttling.
- Sits between the parallel compressor lanes and the serial packer in the Compress path.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 8, payload bits per beat
- ADDR_WIDTH, 3, fifo depth = 2**ADDR_WIDTH
- AF_THRESH, 6, level at or above which almost_full asserts (<= 2**ADDR_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload, requester i at slice i
- req_last  in  NUM_REQ  last beat of packet
- req_ready  out  NUM_REQ  beat accepted when valid & ready
- out_valid  out  1  head entry available
- out_data  out  DATA_WIDTH  head payload
- out_id  out  ID_W  source requester of head (ID_W = clog2(NUM_REQ))
- out_last  out  1  head is last beat of its packet
- out_ready  in  1  consumer pops head
- level  out  ADDR_WIDTH+1  current entry count
- almost_full  out  1  level >= AF_THRESH

Behaviour:
- Internal fifo instance, width DATA_WIDTH+ID_W+1, driven with reset inverted (active-high fifo reset).
- Fifo contract: r_data shows head combinationally while !empty; wr is ignored when full; rd is ignored when empty.
- Reset values: state=IDLE, rr_ptr=0, owner=0, level=0, req_ready=0, out_valid=0, almost_full=0.
- FSM states:
  - IDLE: grant = first asserted req_valid searching from rr_ptr upward, modulo NUM_REQ. req_ready[grant] = !full; all other ready bits 0. Zero-latency: accept in the same cycle.
  - IDLE, accepted beat with last=0: go to LOCKED, owner <= grant.
  - IDLE, accepted beat with last=1: stay IDLE, rr_ptr <= grant+1 (wraps NUM_REQ-1 -> 0).
  - LOCKED: only req_ready[owner] = !full. Other requesters wait even if owner is idle (no interleaving within a packet).
  - LOCKED, accepted beat with last=1: go to IDLE, rr_ptr <= owner+1.
- No valid request, or full: no accept; state and rr_ptr unchanged.
- Write: wr = |(req_valid & req_ready); w_data = {req_last[g], g, req_data[g]}.
- Read:
  - out_valid = !empty; {out_last, out_id, out_data} = r_data.
  - rd = out_valid & out_ready.
  - Unconsumed head stays stable.
- level:
  - +1 on wr only, -1 on rd only, unchanged on both.
  - Never exceeds 2**ADDR_WIDTH; never goes below 0.
  - Full fifo with out_ready=1: a pop occurs, but no write that cycle (ready was low). Write resumes the next cycle.
  - Empty fifo: rd never asserted, so a same-cycle write gives level=1.
- almost_full is registered from the next level value, so it updates in the same edge as level.
- Reset mid-packet: FSM returns to IDLE and the fifo contents are discarded; a partial packet upstream must be restarted by the producer.

Decomposition:
- Package fifo_arb_pkg:
  - ID_W computation function
  - state enum {IDLE, LOCKED}
  - packed struct entry_t {last, id, data}
- Sub-module rr_pick: combinational priority-from-pointer selector.
  - Inputs: req vector, ptr. Outputs: one-hot grant, binary index, any.
  - Used once here; reusable by the decompress side.
- Existing fifo module instanced unchanged.

Test Plan:
- After reset release with all req_valid=1, each requesting single-beat packets (data = 0x10+i) -> fifo order ids 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10.
- Requester 2 sends 3-beat packet 0xA0,0xA1,0xA2 (last on 3rd) while requester 0 is valid -> ready[0]=0 during lock; out sequence id2×3 with last only on 0xA2, then id0.
- Fill with out_ready=0 -> level 1..8; almost_full rises when level becomes 6; at level 8 req_ready=0; one pop -> level 7 and a write the following cycle returns it to 8.
- out_ready=1 with single steady requester at level 3 -> simultaneous wr/rd; level stays 3 for 10 cycles.
- reset asserted low mid-packet (LOCKED, level 4) -> immediately out_valid=0, level=0, req_ready=0; after release, requester 1 is granted first if the only one valid and rr_ptr=0 search order holds.
- Empty fifo, out_ready=1, single beat 0x55 from requester 3 -> out_valid next cycle with out_id=3, out_data=0x55, popped that same cycle, level returns to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write arbiter and its round-robin picker.
// Also intended for reuse by the decompress-side arbiter.
package fifo_arb_pkg;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ID_W       = 2;

    // Entry layout at the default widths; the top builds the same field order at its own widths.
    typedef struct packed {
        logic                      last;
        logic [DEF_ID_W-1:0]       id;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/fifo.sv
// Single-clock fifo with combinational head read; writes ignored when full, reads when empty.
module fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             rd,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wptr_reg;
    logic [ADDR_WIDTH-1:0] rptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  wr_en;
    logic                  rd_en;

    assign full   = (count_reg == DEPTH);
    assign empty  = (count_reg == '0);
    assign wr_en  = wr && !full;
    assign rd_en  = rd && !empty;
    assign r_data = mem[rptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_en) wptr_reg <= wptr_reg + ADDR_WIDTH'(1);
            if (rd_en) rptr_reg <= rptr_reg + ADDR_WIDTH'(1);
            if (wr_en && !rd_en)      count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
            else if (rd_en && !wr_en) count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
        end
    end

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_reg] <= w_data;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational priority selector: first asserted request at or above ptr, wrapping modulo N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Entries carry {last, source id, data}; the read side is a valid/ready stream with a mirrored level.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    localparam int ID_W      = id_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_id,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH:0]           level,
    output logic                          almost_full
);

    typedef struct packed {
        logic                  last;
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AF_THRESH);

    state_t                 state_reg;
    logic [ID_W-1:0]        rr_ptr_reg;
    logic [ID_W-1:0]        owner_reg;
    logic [ADDR_WIDTH:0]    level_reg;
    logic [ADDR_WIDTH:0]    level_next;
    logic                   almost_full_reg;

    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_any;
    logic [ID_W-1:0]        sel_idx;
    logic                   sel_en;
    logic                   sel_last;
    logic [ID_W-1:0]        next_ptr;
    logic                   wr;
    logic                   rd;
    logic                   full;
    logic                   empty;
    fifo_entry_t            w_entry;
    fifo_entry_t            r_entry;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // While a packet is open only its owner may write, even if it has no beat this cycle.
    always_comb begin
        sel_idx   = (state_reg == LOCKED) ? owner_reg : pick_idx;
        sel_en    = (state_reg == LOCKED) ? 1'b1 : (pick_any && (pick_grant != '0));
        req_ready = '0;
        if (sel_en && !full && reset) req_ready[sel_idx] = 1'b1;
        wr        = |(req_valid & req_ready);
        sel_last  = req_last[sel_idx];
        next_ptr  = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + ID_W'(1);
        w_entry   = '{last: sel_last, id: sel_idx, data: data_arr[sel_idx]};
    end

    fifo #(
        .WIDTH      (DATA_WIDTH + ID_W + 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (!reset),
        .wr     (wr),
        .w_data (w_entry),
        .rd     (rd),
        .r_data (r_entry),
        .full   (full),
        .empty  (empty)
    );

    assign out_valid = !empty;
    assign rd        = out_valid && out_ready;
    assign out_last  = r_entry.last;
    assign out_id    = r_entry.id;
    assign out_data  = r_entry.data;

    always_comb begin
        level_next = level_reg;
        if (wr && !rd)      level_next = level_reg + (ADDR_WIDTH+1)'(1);
        else if (rd && !wr) level_next = level_reg - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            owner_reg       <= '0;
            level_reg       <= '0;
            almost_full_reg <= 1'b0;
        end else begin
            level_reg       <= level_next;
            almost_full_reg <= (level_next >= AF_LEVEL);
            if (wr) begin
                unique case (state_reg)
                    IDLE: begin
                        if (!sel_last) begin
                            state_reg <= LOCKED;
                            owner_reg <= sel_idx;
                        end else begin
                            rr_ptr_reg <= next_ptr;
                        end
                    end
                    LOCKED: begin
                        if (sel_last) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= next_ptr;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign level       = level_reg;
    assign almost_full = almost_full_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for round-robin order plus corner-case sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  level;
    logic        almost_full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_THRESH  (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_id;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [3:0]  exp_level;
        logic        exp_af;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_head(input string nm, input logic [1:0] id, input logic [7:0] d, input logic l);
        chk({nm, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_id"}, {30'd0, out_id}, {30'd0, id});
        chk({nm, "_data"}, {24'd0, out_data}, {24'd0, d});
        chk({nm, "_last"}, {31'd0, out_last}, {31'd0, l});
        $display("pop %s id=%0d data=%02h last=%b level=%0d", nm, out_id, out_data, out_last, level);
    endtask

    task automatic drain();
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && level != 0; i++) tick();
        chk("drain_level", {28'd0, level}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;

        for (int k = 0; k < 11; k++) begin
            vecs[k].data = 32'h13121110;
            vecs[k].last = 4'hF;
            if (k < 5) begin
                vecs[k].valid     = 4'hF;
                vecs[k].oready    = 1'b0;
                vecs[k].exp_ready = 4'(1 << (k % 4));
                vecs[k].exp_ov    = (k > 0);
                vecs[k].exp_id    = 2'd0;
                vecs[k].exp_data  = 8'h10;
                vecs[k].exp_level = 4'(k);
            end else begin
                vecs[k].valid     = 4'h0;
                vecs[k].oready    = 1'b1;
                vecs[k].exp_ready = 4'h0;
                vecs[k].exp_ov    = (k < 10);
                vecs[k].exp_id    = 2'((k - 5) % 4);
                vecs[k].exp_data  = 8'h10 + 8'((k - 5) % 4);
                vecs[k].exp_level = 4'(10 - k);
            end
            vecs[k].exp_last = 1'b1;
            vecs[k].exp_af   = 1'b0;
        end

        // Reset state, with requests already present
        req_valid = 4'hF;
        repeat (2) tick();
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_af", {31'd0, almost_full}, 32'd0);
        reset = 1'b1;

        // Round-robin order among four single-beat producers, then pop back
        for (int k = 0; k < 11; k++) begin
            req_valid = vecs[k].valid;
            req_last  = vecs[k].last;
            req_data  = vecs[k].data;
            out_ready = vecs[k].oready;
            settle();
            $display("vec %0d ready=%b ov=%b id=%0d data=%02h level=%0d af=%b",
                     k, req_ready, out_valid, out_id, out_data, level, almost_full);
            chk($sformatf("v%0d_ready", k), {28'd0, req_ready}, {28'd0, vecs[k].exp_ready});
            chk($sformatf("v%0d_ov", k), {31'd0, out_valid}, {31'd0, vecs[k].exp_ov});
            if (vecs[k].exp_ov) begin
                chk($sformatf("v%0d_id", k), {30'd0, out_id}, {30'd0, vecs[k].exp_id});
                chk($sformatf("v%0d_data", k), {24'd0, out_data}, {24'd0, vecs[k].exp_data});
                chk($sformatf("v%0d_last", k), {31'd0, out_last}, {31'd0, vecs[k].exp_last});
            end
            chk($sformatf("v%0d_level", k), {28'd0, level}, {28'd0, vecs[k].exp_level});
            chk($sformatf("v%0d_af", k), {31'd0, almost_full}, {31'd0, vecs[k].exp_af});
            tick();
        end

        // Packet lock: requester 2 holds the port for three beats while requester 0 waits
        out_ready = 1'b0;
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        req_data  = {8'h00, 8'hA0, 8'h00, 8'h33};
        for (int b = 0; b < 3; b++) begin
            req_data[23:16] = 8'hA0 + 8'(b);
            req_last[2]     = (b == 2);
            settle();
            $display("lock beat %0d ready=%b", b, req_ready);
            chk($sformatf("lock_ready%0d", b), {28'd0, req_ready}, 32'b0100);
            tick();
        end
        req_valid = 4'b0001;
        settle();
        chk("after_lock_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        out_ready = 1'b1;
        settle();
        chk("lock_level", {28'd0, level}, 32'd4);
        chk_head("lock0", 2'd2, 8'hA0, 1'b0);
        tick(); settle();
        chk_head("lock1", 2'd2, 8'hA1, 1'b0);
        tick(); settle();
        chk_head("lock2", 2'd2, 8'hA2, 1'b1);
        tick(); settle();
        chk_head("lock3", 2'd0, 8'h33, 1'b1);
        tick();
        drain();

        // Fill to full with almost_full tracking, then one pop and refill
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        out_ready = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            req_data[15:8] = 8'h40 + 8'(k);
            settle();
            $display("fill %0d ready=%b level=%0d af=%b", k, req_ready, level, almost_full);
            chk($sformatf("fill%0d_level", k), {28'd0, level}, k);
            chk($sformatf("fill%0d_af", k), {31'd0, almost_full}, (k >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_ready", k), {28'd0, req_ready}, (k < 8) ? 32'b0010 : 32'd0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("full_pop_ready", {28'd0, req_ready}, 32'd0);
        tick();
        out_ready = 1'b0;
        settle();
        chk("after_pop_level", {28'd0, level}, 32'd7);
        chk("after_pop_af", {31'd0, almost_full}, 32'd1);
        chk("after_pop_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        settle();
        chk("refill_level", {28'd0, level}, 32'd8);
        tick();
        drain();

        // Simultaneous write and read hold the level steady
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        repeat (3) tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            $display("steady %0d level=%0d ready=%b", c, level, req_ready);
            chk($sformatf("steady%0d_level", c), {28'd0, level}, 32'd3);
            tick();
        end
        drain();

        // Reset in the middle of an open packet
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data  = 32'h00C00000;
        repeat (4) tick();
        chk("pre_rst_level", {28'd0, level}, 32'd4);
        reset = 1'b0;
        #1;
        chk("midrst_ov", {31'd0, out_valid}, 32'd0);
        chk("midrst_level", {28'd0, level}, 32'd0);
        chk("midrst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data  = 32'h00007700;
        tick();
        reset = 1'b1;
        settle();
        chk("postrst_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        req_valid = '0;
        settle();
        chk_head("postrst", 2'd1, 8'h77, 1'b1);
        drain();

        // Single beat into an empty fifo with the consumer always ready
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        req_data  = 32'h55000000;
        out_ready = 1'b1;
        settle();
        chk("empty_ready", {28'd0, req_ready}, 32'b1000);
        chk("empty_ov", {31'd0, out_valid}, 32'd0);
        tick();
        req_valid = '0;
        settle();
        chk("empty_level1", {28'd0, level}, 32'd1);
        chk_head("empty", 2'd3, 8'h55, 1'b1);
        tick();
        settle();
        chk("empty_ov_after", {31'd0, out_valid}, 32'd0);
        chk("empty_level0", {28'd0, level}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
